// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU issue controller: opcodes, FSM states,
// instruction field offsets and the legal-opcode test.
package cpu_pkg;

    localparam logic [3:0] OP_0 = 4'h0;
    localparam logic [3:0] OP_1 = 4'h1;
    localparam logic [3:0] OP_2 = 4'h2;
    localparam logic [3:0] OP_3 = 4'h3;
    localparam logic [3:0] OP_4 = 4'h4;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        EXEC,
        WB
    } issue_state_t;

    // Field positions are counted down from the instruction MSB
    localparam int FIELD_W = 4;
    localparam int OPC_OFS = 0;
    localparam int RD_OFS  = 4;
    localparam int RS1_OFS = 8;
    localparam int RS2_OFS = 12;

    function automatic logic is_legal(input logic [3:0] opcode);
        return (opcode <= OP_4);
    endfunction

endpackage

// File: rtl/cpu_issue_ctrl_decode.sv
// Combinational opcode classifier: legal opcode and multi-cycle ALU op flags.
module issue_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       legal,
    output logic       multi_cycle
);

    assign legal       = is_legal(opcode);
    assign multi_cycle = (opcode == OP_4);

endmodule

// File: rtl/cpu_issue_ctrl.sv
// Multi-cycle issue controller: accepts one instruction, then walks it through
// decode, operand read, ALU execute and write-back, one instruction at a time.
module cpu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int N        = 16,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [N-1:0]     instr,
    output logic             rf_rd_en,
    output logic [3:0]       rf_rs1_addr,
    output logic [3:0]       rf_rs2_addr,
    output logic [3:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             rf_we,
    output logic [3:0]       rf_wa,
    output logic             busy,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    issue_state_t      state;
    issue_state_t      state_nxt;
    logic [N-1:0]      ir;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        opcode;
    logic [3:0]        rd;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic              legal;
    logic              multi_cycle;
    logic              wait_expired;

    assign opcode = ir[N-1-OPC_OFS -: FIELD_W];
    assign rd     = ir[N-1-RD_OFS  -: FIELD_W];
    assign rs1    = ir[N-1-RS1_OFS -: FIELD_W];
    assign rs2    = ir[N-1-RS2_OFS -: FIELD_W];

    assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT));

    issue_decode u_decode (
        .opcode      (opcode),
        .legal       (legal),
        .multi_cycle (multi_cycle)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The instruction register only loads in IDLE, so it is frozen while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= '0;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            if (state == IDLE && instr_valid) begin
                ir <= instr;
            end
            if (state == READ) begin
                wait_cnt <= '0;
            end else if (state == EXEC && !alu_done && !wait_expired) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == WB) begin
                retired <= retired + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (instr_valid) state_nxt = DECODE;
            DECODE: state_nxt = legal ? READ : IDLE;
            READ:   state_nxt = EXEC;
            // The timeout check wins over a late alu_done in the expiry cycle
            EXEC: begin
                if (!multi_cycle) begin
                    state_nxt = WB;
                end else if (wait_expired) begin
                    state_nxt = IDLE;
                end else if (alu_done) begin
                    state_nxt = WB;
                end
            end
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE);
        busy        = (state != IDLE);
        illegal     = 1'b0;
        rf_rd_en    = 1'b0;
        rf_rs1_addr = '0;
        rf_rs2_addr = '0;
        alu_op      = '0;
        alu_start   = 1'b0;
        timeout     = 1'b0;
        rf_we       = 1'b0;
        rf_wa       = '0;
        case (state)
            DECODE: illegal = !legal;
            READ: begin
                rf_rd_en    = 1'b1;
                rf_rs1_addr = rs1;
                rf_rs2_addr = rs2;
            end
            // wait_cnt is still zero only in the first EXEC cycle
            EXEC: begin
                alu_op    = opcode;
                alu_start = (wait_cnt == '0);
                timeout   = multi_cycle && wait_expired;
            end
            WB: begin
                rf_wa = rd;
                rf_we = (rd != 4'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Directed self-checking bench for cpu_issue_ctrl: handshake latency, multi-cycle
// wait, illegal opcode, timeout, r0 write-back suppression and mid-flight reset.
module tb_cpu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        rf_rd_en;
    logic [3:0]  rf_rs1_addr;
    logic [3:0]  rf_rs2_addr;
    logic [3:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic        busy;
    logic        illegal;
    logic        timeout;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;

    cpu_issue_ctrl #(.N(16), .MAX_WAIT(15), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_rd_en    (rf_rd_en),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .alu_op      (alu_op),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .busy        (busy),
        .illegal     (illegal),
        .timeout     (timeout),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Handshake on the next rising edge, then scramble instr to prove it is not re-sampled
    task automatic applyStimulus(input logic [15:0] word);
        instr_valid = 1'b1;
        instr       = word;
        step();
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        alu_done    = 1'b0;

        // Reset state
        step();
        checkOutput("rst_ready", instr_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_retired", retired, 0);
        checkOutput("rst_we", rf_we, 0);
        checkOutput("rst_rd_en", rf_rd_en, 0);
        rst = 1'b0;
        step();

        // Single-cycle op 0x0123
        $display("[TB] single-cycle op 0x0123");
        applyStimulus(16'h0123);
        checkOutput("t1_dec_busy", busy, 1);
        checkOutput("t1_dec_ready", instr_ready, 0);
        checkOutput("t1_dec_illegal", illegal, 0);
        step();
        checkOutput("t1_rd_en", rf_rd_en, 1);
        checkOutput("t1_rs1", rf_rs1_addr, 2);
        checkOutput("t1_rs2", rf_rs2_addr, 3);
        step();
        checkOutput("t1_start", alu_start, 1);
        checkOutput("t1_op", alu_op, 0);
        checkOutput("t1_exec_rd_en", rf_rd_en, 0);
        step();
        checkOutput("t1_we", rf_we, 1);
        checkOutput("t1_wa", rf_wa, 1);
        step();
        checkOutput("t1_retired", retired, 1);
        checkOutput("t1_ready", instr_ready, 1);

        // Multi-cycle op 0x4567, alu_done three cycles after alu_start
        $display("[TB] multi-cycle op 0x4567");
        applyStimulus(16'h4567);
        step();
        checkOutput("t2_rs1", rf_rs1_addr, 6);
        checkOutput("t2_rs2", rf_rs2_addr, 7);
        step();
        checkOutput("t2_start1", alu_start, 1);
        checkOutput("t2_op1", alu_op, 4);
        step();
        checkOutput("t2_start2", alu_start, 0);
        checkOutput("t2_op2", alu_op, 4);
        checkOutput("t2_we2", rf_we, 0);
        step();
        checkOutput("t2_start3", alu_start, 0);
        checkOutput("t2_busy3", busy, 1);
        step();
        alu_done = 1'b1;
        checkOutput("t2_start4", alu_start, 0);
        checkOutput("t2_op4", alu_op, 4);
        step();
        alu_done = 1'b0;
        checkOutput("t2_we", rf_we, 1);
        checkOutput("t2_wa", rf_wa, 5);
        step();
        checkOutput("t2_retired", retired, 2);

        // Illegal opcode 0x9ABC
        $display("[TB] illegal op 0x9ABC");
        applyStimulus(16'h9ABC);
        checkOutput("t3_illegal", illegal, 1);
        checkOutput("t3_rd_en", rf_rd_en, 0);
        step();
        checkOutput("t3_ready", instr_ready, 1);
        checkOutput("t3_illegal_clr", illegal, 0);
        checkOutput("t3_we", rf_we, 0);
        checkOutput("t3_retired", retired, 2);

        // Multi-cycle op with alu_done held low -> timeout in the 16th EXEC cycle
        $display("[TB] timeout op 0x4ABC");
        applyStimulus(16'h4ABC);
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
            checkOutput("t4_wait_timeout", timeout, 0);
            checkOutput("t4_wait_busy", busy, 1);
        end
        step();
        checkOutput("t4_timeout", timeout, 1);
        checkOutput("t4_to_we", rf_we, 0);
        step();
        checkOutput("t4_ready", instr_ready, 1);
        checkOutput("t4_timeout_clr", timeout, 0);
        checkOutput("t4_we", rf_we, 0);
        checkOutput("t4_retired", retired, 2);

        // rd = 0: no write enable but still retires
        $display("[TB] r0 destination 0x2012");
        applyStimulus(16'h2012);
        step();
        checkOutput("t5_rs1", rf_rs1_addr, 1);
        checkOutput("t5_rs2", rf_rs2_addr, 2);
        step();
        checkOutput("t5_op", alu_op, 2);
        step();
        checkOutput("t5_wb_busy", busy, 1);
        checkOutput("t5_we", rf_we, 0);
        step();
        checkOutput("t5_retired", retired, 3);

        // Reset mid-EXEC of a multi-cycle op
        $display("[TB] reset during EXEC");
        applyStimulus(16'h4567);
        step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_op", alu_op, 0);
        checkOutput("t6_ready", instr_ready, 1);
        checkOutput("t6_retired", retired, 0);
        step();
        rst = 1'b0;
        step();
        applyStimulus(16'h1321);
        step();
        checkOutput("t6_rs1", rf_rs1_addr, 2);
        checkOutput("t6_rs2", rf_rs2_addr, 1);
        step();
        checkOutput("t6_alu_op", alu_op, 1);
        step();
        checkOutput("t6_we", rf_we, 1);
        checkOutput("t6_wa", rf_wa, 3);
        step();
        checkOutput("t6_retired_after", retired, 1);

        // Reset during WB drops rf_we immediately and loses the retirement
        $display("[TB] reset during WB");
        applyStimulus(16'h0123);
        step();
        step();
        step();
        checkOutput("t7_we_before", rf_we, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t7_we_async", rf_we, 0);
        checkOutput("t7_retired", retired, 0);
        step();
        rst = 1'b0;
        step();
        checkOutput("t7_ready", instr_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
